// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART receive path.
package uart_pkg;

  localparam int unsigned BAUD_DIV_DEF  = 1250;
  localparam int unsigned DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/baud_tick_mid.sv
// Gated baud counter producing one tick per bit period, placed at mid-bit
// relative to the cycle the enable first went high.
module baud_tick_mid
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned LAST  = BAUD_DIV - 1;
  localparam int unsigned MID   = (BAUD_DIV / 2) - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en) begin
      if (cnt_q == CNT_W'(LAST)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_W'(MID));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx, frames start/data/stop bits and
// hands each byte to the consumer through a single-entry holding register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  uart_rx_ctrl_if.master    bus,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun_err
);

  localparam int unsigned BIT_W    = $clog2(DATA_BITS + 1);
  localparam int unsigned LAST_BIT = DATA_BITS - 1;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_START = 2'(START);
  localparam logic [1:0] S_DATA  = 2'(DATA);
  localparam logic [1:0] S_STOP  = 2'(STOP);

  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;

  logic [1:0]           state_q,   state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;
  logic                 ovr_q,     ovr_d;
  logic                 busy_q,    busy_d;

  logic                 baud_en_c;
  logic                 tick_c;
  logic                 accept_c;

  assign baud_en_c = (state_q != S_IDLE);

  baud_tick_mid #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (baud_en_c),
    .tick  (tick_c)
  );

  assign accept_c = valid_q && bus.rx_ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (accept_c) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick_c) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end

      S_DATA: begin
        if (tick_c) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(LAST_BIT)) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (tick_c) begin
          state_d = S_IDLE;
          // A byte landing in the same cycle the old one drains is not an overrun.
          if (rx_s_q) begin
            if (!valid_q || accept_c) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Sync flops reset high so a line held low through reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign rx_busy      = busy_q;
  assign frame_err    = ferr_q;
  assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame-level reference model plus
// directed sequences for glitch, framing, overrun, handshake and reset cases.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned BAUD = 16;
  localparam int unsigned DB   = 8;
  // rx fall -> load edge: 3 (sync+detect) + half bit + start and data bits
  localparam int LOAD_LAT = 3 + BAUD / 2 + (DB + 1) * BAUD;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rx    = 1'b1;
  logic rx_busy, frame_err, overrun_err;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_rx_ctrl #(
    .BAUD_DIV  (BAUD),
    .DATA_BITS (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .bus         (bus.master),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: each frame becomes one event at its stop-tick edge.
  typedef struct {
    int         edge_n;
    logic [7:0] data;
    logic       stop;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       e_fe    = 1'b0;
  logic       e_ovr   = 1'b0;
  logic       acc;
  bit         mon_en  = 1'b0;

  always @(posedge clk) begin
    cyc   = cyc + 1;
    e_fe  = 1'b0;
    e_ovr = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      acc = m_valid && bus.rx_ready;
      if (acc) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].edge_n == cyc) begin
        ev = evq.pop_front();
        if (!ev.stop)      e_fe = 1'b1;
        else if (m_valid)  e_ovr = 1'b1;
        else begin
          m_valid = 1'b1;
          m_data  = ev.data;
        end
      end
    end
    #1;
    if (mon_en)
      check("model_cycle {valid,ferr,ovr,data}",
            32'({bus.rx_valid, frame_err, overrun_err, bus.rx_data}),
            32'({m_valid, e_fe, e_ovr, m_data}));
  end

  logic [7:0] dut_xfer_q[$];
  int         ovr_seen = 0;

  always @(posedge clk)
    if (rst_n && bus.rx_valid && bus.rx_ready) dut_xfer_q.push_back(bus.rx_data);

  always @(negedge clk)
    if (overrun_err) ovr_seen++;

  // Drives one frame LSB first; must be called just after a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int low_hold, input int idle);
    logic [9:0] bits;
    ev_t        e;
    bits     = {stop, d, 1'b0};
    e.edge_n = cyc + LOAD_LAT;
    e.data   = d;
    e.stop   = stop;
    evq.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BAUD) @(negedge clk);
    end
    if (low_hold > 0) begin
      rx = 1'b0;
      repeat (low_hold) @(negedge clk);
    end
    rx = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];
  int   busy_first, busy_clear, fe_cnt, busy_cnt;
  bit   rand_run;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[5] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1'b1};

    bus.rx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs {valid,busy,ferr,ovr,data}",
          32'({bus.rx_valid, rx_busy, frame_err, overrun_err, bus.rx_data}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5: rx_valid high for exactly one cycle, LOAD_LAT edges after the fall
    bus.rx_ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1, 0, 10);
      begin
        repeat (LOAD_LAT - 1) @(negedge clk);
        check("a5_valid_before", 32'(bus.rx_valid), 32'd0);
        @(negedge clk);
        check("a5_valid_at_155", 32'(bus.rx_valid), 32'd1);
        check("a5_data", 32'(bus.rx_data), 32'hA5);
        @(negedge clk);
        check("a5_valid_after", 32'(bus.rx_valid), 32'd0);
      end
    join

    for (int i = 0; i < 6; i++) begin
      fork
        send_frame(vecs[i].data, vecs[i].stop, 0, 4);
        begin
          repeat (LOAD_LAT) @(negedge clk);
          check($sformatf("tbl%0d_valid", i), 32'(bus.rx_valid), 32'(vecs[i].exp_valid));
          if (vecs[i].exp_valid)
            check($sformatf("tbl%0d_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_data));
          check($sformatf("tbl%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_fe));
        end
      join
    end

    // 4-cycle low glitch: rejected at the first (mid start bit) tick
    busy_first = -1;
    busy_clear = -1;
    rx = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4) rx = 1'b1;
      if (rx_busy && busy_first < 0) busy_first = i;
      if (!rx_busy && busy_first >= 0 && busy_clear < 0) busy_clear = i;
    end
    check("glitch_busy_rise_edge", 32'(busy_first), 32'd3);
    check("glitch_busy_clear_edge", 32'(busy_clear), 32'd11);

    // Bad stop bit, then line held low 40 cycles: one frame_err, no restart
    fe_cnt   = 0;
    busy_cnt = 0;
    fork
      send_frame(8'h3C, 1'b0, 40, 30);
      begin
        for (int i = 1; i <= 230; i++) begin
          @(negedge clk);
          if (frame_err) fe_cnt++;
          if (i > LOAD_LAT && rx_busy) busy_cnt++;
        end
      end
    join
    check("ferr_pulse_count", 32'(fe_cnt), 32'd1);
    check("ferr_no_restart_busy", 32'(busy_cnt), 32'd0);
    check("ferr_valid", 32'(bus.rx_valid), 32'd0);

    // Consumer stalled: second frame overruns, first byte retained
    bus.rx_ready = 1'b0;
    ovr_seen     = 0;
    dut_xfer_q.delete();
    send_frame(8'h11, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 0, 20);
    check("ovr_valid_held", 32'(bus.rx_valid), 32'd1);
    check("ovr_data_retained", 32'(bus.rx_data), 32'h11);
    check("ovr_pulse_count", 32'(ovr_seen), 32'd1);
    bus.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_xfer_count", 32'(dut_xfer_q.size()), 32'd1);
    if (dut_xfer_q.size() > 0) check("ovr_xfer_data", 32'(dut_xfer_q[0]), 32'h11);
    check("ovr_drained", 32'(bus.rx_valid), 32'd0);

    // Accept in the very cycle the second byte loads
    bus.rx_ready = 1'b0;
    ovr_seen     = 0;
    send_frame(8'h11, 1'b1, 0, 0);
    dut_xfer_q.delete();
    fork
      send_frame(8'h22, 1'b1, 0, 10);
      begin
        repeat (LOAD_LAT - 1) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        check("same_cycle_valid", 32'(bus.rx_valid), 32'd1);
        check("same_cycle_data", 32'(bus.rx_data), 32'h22);
        check("same_cycle_no_ovr", 32'(overrun_err), 32'd0);
      end
    join
    check("same_cycle_xfer_count", 32'(dut_xfer_q.size()), 32'd1);
    if (dut_xfer_q.size() > 0) check("same_cycle_xfer_data", 32'(dut_xfer_q[0]), 32'h11);
    check("same_cycle_ovr_count", 32'(ovr_seen), 32'd0);
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("same_cycle_drain_count", 32'(dut_xfer_q.size()), 32'd2);
    if (dut_xfer_q.size() > 1) check("same_cycle_drain_data", 32'(dut_xfer_q[1]), 32'h22);

    // Reset mid-DATA of 0xFF, then a clean 0x5A
    fork
      send_frame(8'hFF, 1'b1, 0, 10);
      begin
        repeat (80) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs {valid,busy,ferr,ovr,data}",
              32'({bus.rx_valid, rx_busy, frame_err, overrun_err, bus.rx_data}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check("post_reset_idle", 32'(rx_busy), 32'd0);
    fork
      send_frame(8'h5A, 1'b1, 0, 10);
      begin
        repeat (LOAD_LAT) @(negedge clk);
        check("post_reset_valid", 32'(bus.rx_valid), 32'd1);
        check("post_reset_data", 32'(bus.rx_data), 32'h5A);
      end
    join

    // Random frames, stop bits, gaps and consumer back-pressure
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [7:0] d;
          logic       s;
          d = 8'($urandom);
          s = ($urandom_range(0, 3) != 0);
          send_frame(d, s, 0, s ? $urandom_range(0, 12) : $urandom_range(2, 12));
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          @(negedge clk);
          bus.rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("final_drained", 32'(bus.rx_valid), 32'd0);
    check("final_events_consumed", 32'(evq.size()), 32'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
